mod_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-bit wrap counter.
- Provides a modulo-N up/down counter with synchronous load, a wrap or saturate end mode, a terminal-count pulse, and a half-period square output.
- Used as a general event/tick counter and clock-enable divider in datapath and timer blocks.
- All state is in the `clk` domain.

---
 rtl/mod_counter.sv | 136 +++++++++++++
 tb/tb_mod_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter -- parametrised modulo-N up/down counter.
//
// Counts over 0..MODULO-1 in either direction, with a synchronous clamped load,
// wrap or saturate behaviour at the ends, a combinational terminal-count pulse
// and a registered half-period square output.
//
// Optional feature (macro MOD_COUNTER_PRESCALE_EN): an internal prescaler counts
// enabled cycles and only every PRESCALE-th enabled cycle becomes a count step.
// With the macro undefined every enabled cycle is a step and PRESCALE is unused.
//
// Parameters:
//   WIDTH    counter width in bits (1..32)
//   MODULO   count range 0..MODULO-1 (2..2**WIDTH)
//   SATURATE 0 = wrap at the ends, 1 = hold at the ends
//   PRESCALE enabled cycles per step (1..256), prescaler build only
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   en        count enable
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load strobe (beats a step in the same cycle)
//   load_val  load value, clamped to MODULO-1
//   cnt       current count (registered)
//   tc        terminal-count pulse, high in the cycle whose edge wraps/holds
//   out_p     registered, high while cnt >= MODULO/2
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULO   = 16,
  parameter int     SATURATE = 0,
  parameter int     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             out_p
);

  // Elaboration-time legality check of the parameter set.
  if (WIDTH < 1 || WIDTH > 32 || MODULO < 2 || MODULO > (longint'(1) << WIDTH) ||
      PRESCALE < 1 || PRESCALE > 256) begin : g_bad_param
    $error("mod_counter: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] HALF_VAL = WIDTH'(MODULO / 2);

  logic [WIDTH-1:0] r_cnt;
  logic             r_out_p;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_step;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_at_end;

`ifdef MOD_COUNTER_PRESCALE_EN
  // Prescaler needs at least one bit even when PRESCALE=1; it then sits at 0,
  // which equals PS_MAX, so every enabled cycle steps.
  localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_ps;

  assign w_step = en & (r_ps == PS_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      r_ps <= '0;
    end else if (en) begin
      r_ps <= (r_ps == PS_MAX) ? '0 : r_ps + 1'b1;
    end
  end
`else
  assign w_step = en;
`endif

  assign w_at_top = (r_cnt == MAX_VAL);
  assign w_at_bot = (r_cnt == '0);
  assign w_at_end = up ? w_at_top : w_at_bot;

  // Terminal count: only a real step (not a load, not in reset) at the end
  // value in the current direction.
  assign tc = w_step & ~load & rst_n & w_at_end;

  // Comparison done in 64 bits so no compare collapses to a constant when
  // MODULO == 2**WIDTH.
  assign w_load_clamped = (longint'(load_val) > MODULO - 1) ? MAX_VAL : load_val;

  // NOTE: every path of a combinational block must assign its outputs; the
  // leading default keeps this block free of inferred latches.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (load) begin
      w_cnt_nxt = w_load_clamped;
    end else if (w_step) begin
      if (up) begin
        if (!w_at_top)          w_cnt_nxt = r_cnt + 1'b1;
        else if (SATURATE == 0) w_cnt_nxt = '0;
      end else begin
        if (!w_at_bot)          w_cnt_nxt = r_cnt - 1'b1;
        else if (SATURATE == 0) w_cnt_nxt = MAX_VAL;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_out_p <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      // Derived from the next state so out_p lines up with cnt.
      r_out_p <= (w_cnt_nxt >= HALF_VAL);
    end
  end

  assign cnt   = r_cnt;
  assign out_p = r_out_p;

`ifdef FORMAL
  a_cnt_range : assert property (@(posedge clk) r_cnt <= MAX_VAL);
  a_out_p_rise : assert property (@(posedge clk) $rose(r_out_p) |-> (r_cnt >= HALF_VAL));
  a_tc_end : assert property (@(posedge clk) tc |-> (w_at_top || w_at_bot));
`endif

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter -- scoreboard bench for mod_counter.
//
// Three instances share one stimulus stream:
//   dut0: WIDTH=4 MODULO=16 wrap      (full-range modulo)
//   dut1: WIDTH=4 MODULO=10 wrap
//   dut2: WIDTH=4 MODULO=10 saturate
// The driver computes each cycle's expected cnt/out_p/tc from an arithmetic
// reference model and queues them; a monitor on the falling edge pops the
// queue and compares against the instances.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  localparam int N   = 3;
  localparam int PRE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] cnt_w [N];
  logic       tc_w  [N];
  logic       outp_w[N];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0), .PRESCALE(PRE)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .cnt(cnt_w[0]), .tc(tc_w[0]), .out_p(outp_w[0]));
  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(PRE)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .cnt(cnt_w[1]), .tc(tc_w[1]), .out_p(outp_w[1]));
  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(PRE)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .cnt(cnt_w[2]), .tc(tc_w[2]), .out_p(outp_w[2]));

  typedef struct {
    int idx;
    int cnt;
    bit outp;
    bit tc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int m_cnt[N];
  int m_ps;

  function automatic int mod_of(input int i);
    return (i == 0) ? 16 : 10;
  endfunction

  function automatic bit sat_of(input int i);
    return (i == 2);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs (called #1 after a rising edge), queue what the
  // instances must show during this cycle, advance the model, step a clock.
  task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lv);
    bit step;
    int m, c;
    rst_n    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = 4'(lv);
`ifdef MOD_COUNTER_PRESCALE_EN
    step = e && (m_ps == PRE - 1);
`else
    step = e;
`endif
    for (int i = 0; i < N; i++) begin
      exp_t x;
      m      = mod_of(i);
      c      = m_cnt[i];
      x.idx  = i;
      x.cnt  = c;
      x.outp = (c >= m / 2);
      x.tc   = r && !l && step && (u ? (c == m - 1) : (c == 0));
      q.push_back(x);
      if (!r) begin
        m_cnt[i] = 0;
      end else if (l) begin
        m_cnt[i] = (lv > m - 1) ? m - 1 : lv;
      end else if (step) begin
        if (u) m_cnt[i] = sat_of(i) ? ((c + 1 > m - 1) ? m - 1 : c + 1) : (c + 1) % m;
        else   m_cnt[i] = sat_of(i) ? ((c == 0) ? 0 : c - 1) : (c + m - 1) % m;
      end
    end
    if (!r || l)   m_ps = 0;
    else if (e)    m_ps = (m_ps + 1) % PRE;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares everything the driver queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      check($sformatf("dut%0d_cnt", x.idx),  int'(cnt_w[x.idx]),  x.cnt);
      check($sformatf("dut%0d_outp", x.idx), int'(outp_w[x.idx]), int'(x.outp));
      check($sformatf("dut%0d_tc", x.idx),   int'(tc_w[x.idx]),   int'(x.tc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ps = 0;
    @(posedge clk);
    #1;

    // Held in reset with en=1, down at cnt=0: tc must stay low.
    drive(0, 1, 0, 0, 0);

    // Count up 17 cycles from 0: wrap at 15 / 9, saturate at 9.
    for (int k = 0; k < 17; k++) drive(1, 1, 1, 0, 0);

    // Load 3, count down 5 cycles through 0.
    drive(1, 0, 0, 1, 3);
    for (int k = 0; k < 5; k++) drive(1, 1, 0, 0, 0);

    // Clamped load of 12, then push against the top, then step down.
    drive(1, 0, 0, 1, 12);
    for (int k = 0; k < 3; k++) drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);

    // Load beats step; reset beats enable.
    drive(1, 0, 0, 1, 5);
    drive(1, 1, 1, 1, 2);
    drive(0, 1, 1, 0, 0);

    // en toggling from 7, then direction change mid-sequence.
    drive(1, 0, 0, 1, 7);
    for (int k = 0; k < 6; k++) drive(1, (k % 2) == 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) drive(1, (k % 2) == 0, 0, 0, 0);

    // 12 enabled cycles with a load on cycle 6 (prescaler restart).
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) drive(1, 1, 1, k == 6, 1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
